lcd_nibble_writer: RTL and testbench

LCD_NIBBLE_WRITER -- requirements
Module: lcd_nibble_writer

---
 rtl/lcd_nibble_writer.sv | 165 ++++++++++++++++
 tb/tb_lcd_nibble_writer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_nibble_writer.sv
// HD44780-style 4-bit LCD writer: runs the power-on init sequence, then sends
// accepted bytes as high/low nibbles with setup, enable and gap timing.
module lcd_nibble_writer #(
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned ENABLE_CYC  = 12,
  parameter int unsigned NIBBLE_GAP  = 50,
  parameter int unsigned BYTE_GAP    = 2000,
  parameter int unsigned POWERUP_CYC = 750000,
  parameter int unsigned INIT_GAP1   = 205000,
  parameter int unsigned INIT_GAP2   = 5000,
  parameter int unsigned INIT_GAP3   = 2000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iData,
  input  logic       iRS,
  input  logic       iValid,
  output logic       oReady,
  output logic       oInitDone,
  output logic       oLCD_E,
  output logic       oLCD_RS,
  output logic       oLCD_RW,
  output logic [3:0] oLCD_Data
);

  localparam int unsigned CNT_W = ($clog2(POWERUP_CYC + 1) > 20) ? $clog2(POWERUP_CYC + 1) : 20;

  typedef enum logic [3:0] {
    POWERUP, INIT_SETUP, INIT_EN, INIT_WAIT, IDLE,
    HI_SETUP, HI_EN, NIB_GAP, LO_SETUP, LO_EN, BYTE_WAIT
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       byte_q, byte_d;
  logic             brs_q, brs_d;
  logic [3:0]       nib_q, nib_d;
  logic             rs_q, rs_d;
  logic             e_q, ready_q, done_q;
  logic             cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  // Next state, counter reloads (value-1) and the nibble/RS presented on the bus
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_zero ? cnt_q : cnt_q - CNT_W'(1);
    idx_d   = idx_q;
    byte_d  = byte_q;
    brs_d   = brs_q;
    unique case (state_q)
      POWERUP: if (cnt_zero) begin
        state_d = INIT_SETUP;
        cnt_d   = CNT_W'(SETUP_CYC - 1);
      end
      INIT_SETUP: if (cnt_zero) begin
        state_d = INIT_EN;
        cnt_d   = CNT_W'(ENABLE_CYC - 1);
      end
      INIT_EN: if (cnt_zero) begin
        state_d = INIT_WAIT;
        unique case (idx_q)
          2'd0:    cnt_d = CNT_W'(INIT_GAP1 - 1);
          2'd1:    cnt_d = CNT_W'(INIT_GAP2 - 1);
          default: cnt_d = CNT_W'(INIT_GAP3 - 1);
        endcase
      end
      INIT_WAIT: if (cnt_zero) begin
        if (idx_q == 2'd3) begin
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = INIT_SETUP;
          cnt_d   = CNT_W'(SETUP_CYC - 1);
        end
      end
      IDLE: if (iValid) begin
        byte_d  = iData;
        brs_d   = iRS;
        state_d = HI_SETUP;
        cnt_d   = CNT_W'(SETUP_CYC - 1);
      end
      HI_SETUP: if (cnt_zero) begin
        state_d = HI_EN;
        cnt_d   = CNT_W'(ENABLE_CYC - 1);
      end
      HI_EN: if (cnt_zero) begin
        state_d = NIB_GAP;
        cnt_d   = CNT_W'(NIBBLE_GAP - 1);
      end
      NIB_GAP: if (cnt_zero) begin
        state_d = LO_SETUP;
        cnt_d   = CNT_W'(SETUP_CYC - 1);
      end
      LO_SETUP: if (cnt_zero) begin
        state_d = LO_EN;
        cnt_d   = CNT_W'(ENABLE_CYC - 1);
      end
      LO_EN: if (cnt_zero) begin
        state_d = BYTE_WAIT;
        cnt_d   = CNT_W'(BYTE_GAP - 1);
      end
      BYTE_WAIT: if (cnt_zero) begin
        state_d = IDLE;
      end
      default: begin
        state_d = POWERUP;
        cnt_d   = CNT_W'(POWERUP_CYC - 1);
      end
    endcase

    // Bus values change only when a setup phase starts, so they hold through the following gap
    nib_d = nib_q;
    rs_d  = rs_q;
    if (state_d != state_q) begin
      unique case (state_d)
        INIT_SETUP: begin
          nib_d = (idx_d == 2'd3) ? 4'h2 : 4'h3;
          rs_d  = 1'b0;
        end
        HI_SETUP: begin
          nib_d = byte_d[7:4];
          rs_d  = brs_d;
        end
        LO_SETUP: nib_d = byte_q[3:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= POWERUP;
      cnt_q   <= CNT_W'(POWERUP_CYC - 1);
      idx_q   <= 2'd0;
      byte_q  <= 8'h00;
      brs_q   <= 1'b0;
      nib_q   <= 4'h0;
      rs_q    <= 1'b0;
      e_q     <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      brs_q   <= brs_d;
      nib_q   <= nib_d;
      rs_q    <= rs_d;
      e_q     <= (state_d == INIT_EN) || (state_d == HI_EN) || (state_d == LO_EN);
      ready_q <= (state_d == IDLE);
      done_q  <= done_q | (state_d == IDLE);
    end
  end

  assign oReady    = ready_q;
  assign oInitDone = done_q;
  assign oLCD_E    = e_q;
  assign oLCD_RS   = rs_q;
  assign oLCD_RW   = 1'b0;
  assign oLCD_Data = nib_q;

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Directed bench for lcd_nibble_writer with small timing parameters; a negedge
// monitor records every E pulse so tests compare nibbles, widths and spacing.
module tb_lcd_nibble_writer;

  logic       clk = 1'b0;
  logic       Reset;
  logic [7:0] iData;
  logic       iRS;
  logic       iValid;
  logic       oReady, oInitDone, oLCD_E, oLCD_RS, oLCD_RW;
  logic [3:0] oLCD_Data;

  lcd_nibble_writer #(
    .SETUP_CYC(2), .ENABLE_CYC(3), .NIBBLE_GAP(4), .BYTE_GAP(5),
    .POWERUP_CYC(10), .INIT_GAP1(6), .INIT_GAP2(5), .INIT_GAP3(4)
  ) dut (
    .Clock(clk), .Reset(Reset), .iData(iData), .iRS(iRS), .iValid(iValid),
    .oReady(oReady), .oInitDone(oInitDone), .oLCD_E(oLCD_E), .oLCD_RS(oLCD_RS),
    .oLCD_RW(oLCD_RW), .oLCD_Data(oLCD_Data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] data;
    logic       rs;
    int         rise;
    int         fall;
    bit         stable;
  } pulse_t;

  typedef struct {
    logic [7:0] data;
    logic       rs;
    logic [3:0] exp_hi;
    logic [3:0] exp_lo;
  } vec_t;

  pulse_t pq[$];
  pulse_t cur;
  bit     in_pulse = 1'b0;
  bit     prev_rdy = 1'b0;
  bit     prev_done = 1'b0;
  int     cyc = 0;
  int     rdy_rise = -1;
  int     done_rise = -1;
  int     passed = 0;
  int     total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse recorder: rise = first cycle E seen high, fall = first cycle seen low again
  always @(negedge clk) begin
    if (Reset) begin
      in_pulse  = 1'b0;
      prev_rdy  = 1'b0;
      prev_done = 1'b0;
      rdy_rise  = -1;
      done_rise = -1;
    end else begin
      if (oLCD_E && !in_pulse) begin
        in_pulse   = 1'b1;
        cur.data   = oLCD_Data;
        cur.rs     = oLCD_RS;
        cur.rise   = cyc;
        cur.stable = 1'b1;
      end else if (oLCD_E && in_pulse) begin
        if (oLCD_Data != cur.data || oLCD_RS != cur.rs) cur.stable = 1'b0;
      end else if (!oLCD_E && in_pulse) begin
        in_pulse = 1'b0;
        cur.fall = cyc;
        pq.push_back(cur);
      end
      if (oReady && !prev_rdy) rdy_rise = cyc;
      if (oInitDone && !prev_done) done_rise = cyc;
      prev_rdy  = oReady;
      prev_done = oInitDone;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic pulse_t pget(input int i);
    pulse_t p;
    p.data = 4'h0; p.rs = 1'b0; p.rise = -1000; p.fall = -2000; p.stable = 1'b0;
    if (i < pq.size()) p = pq[i];
    return p;
  endfunction

  task automatic wait_pulses(input int n, input string name);
    for (int i = 0; i < 500 && pq.size() < n; i++) step();
    chk({name, " pulse count"}, pq.size(), n);
  endtask

  task automatic wait_ready(input string name);
    int k;
    for (k = 0; k < 500 && !oReady; k++) step();
    chk({name, " ready reached"}, int'(oReady), 1);
  endtask

  // Power-on init: four pulses 3,3,3,2 with RS=0, gaps INIT_GAPn+SETUP, then done+ready together
  task automatic check_init(input int rel);
    pulse_t p, q;
    int exp_gap[3] = '{8, 7, 6};
    wait_pulses(4, "init");
    for (int i = 0; i < 4; i++) begin
      p = pget(i);
      chk($sformatf("init%0d data", i), int'(p.data), (i == 3) ? 2 : 3);
      chk($sformatf("init%0d rs", i), int'(p.rs), 0);
      chk($sformatf("init%0d width", i), p.fall - p.rise, 3);
      chk($sformatf("init%0d stable", i), int'(p.stable), 1);
      if (i > 0) begin
        q = pget(i - 1);
        chk($sformatf("init%0d gap", i), p.rise - q.fall, exp_gap[i-1]);
      end
    end
    chk("init first rise", pget(0).rise - rel, 12);
    chk("init done early", int'(oInitDone), 0);
    wait_ready("init");
    chk("init done with ready", done_rise, rdy_rise);
    chk("init ready after last fall", rdy_rise - pget(3).fall, 4);
    chk("init done level", int'(oInitDone), 1);
  endtask

  vec_t vecs[5];

  initial begin
    int rel;
    pulse_t h, l;
    vecs[0] = '{8'h41, 1'b1, 4'h4, 4'h1};
    vecs[1] = '{8'h28, 1'b0, 4'h2, 4'h8};
    vecs[2] = '{8'h0C, 1'b0, 4'h0, 4'hC};
    vecs[3] = '{8'hA5, 1'b1, 4'hA, 4'h5};
    vecs[4] = '{8'hF0, 1'b0, 4'hF, 4'h0};

    Reset = 1'b1; iData = 8'h00; iRS = 1'b0; iValid = 1'b0;
    repeat (3) step();
    chk("reset E", int'(oLCD_E), 0);
    chk("reset RS", int'(oLCD_RS), 0);
    chk("reset RW", int'(oLCD_RW), 0);
    chk("reset data", int'(oLCD_Data), 0);
    chk("reset ready", int'(oReady), 0);
    chk("reset done", int'(oInitDone), 0);
    Reset = 1'b0;
    rel = cyc;
    check_init(rel);

    // Single-cycle requests; inputs scrambled while busy must not leak
    foreach (vecs[v]) begin
      pq.delete();
      wait_ready($sformatf("vec%0d", v));
      iValid = 1'b1; iData = vecs[v].data; iRS = vecs[v].rs;
      step();
      iValid = 1'b0;
      chk($sformatf("vec%0d ready drop", v), int'(oReady), 0);
      for (int i = 0; i < 200 && !oReady; i++) begin
        iData = 8'($urandom); iRS = 1'($urandom);
        step();
      end
      repeat (6) begin
        iData = 8'($urandom); iRS = 1'($urandom);
        step();
      end
      chk($sformatf("vec%0d pulse count", v), pq.size(), 2);
      h = pget(0); l = pget(1);
      chk($sformatf("vec%0d hi", v), int'(h.data), int'(vecs[v].exp_hi));
      chk($sformatf("vec%0d lo", v), int'(l.data), int'(vecs[v].exp_lo));
      chk($sformatf("vec%0d rs hi", v), int'(h.rs), int'(vecs[v].rs));
      chk($sformatf("vec%0d rs lo", v), int'(l.rs), int'(vecs[v].rs));
      chk($sformatf("vec%0d width hi", v), h.fall - h.rise, 3);
      chk($sformatf("vec%0d width lo", v), l.fall - l.rise, 3);
      chk($sformatf("vec%0d stable", v), int'(h.stable && l.stable), 1);
      chk($sformatf("vec%0d nibble gap", v), l.rise - h.fall, 6);
      chk($sformatf("vec%0d ready after lo", v), rdy_rise - l.fall, 5);
      chk($sformatf("vec%0d rw", v), int'(oLCD_RW), 0);
    end

    // Back-to-back with iValid held high: 0x28 then 0x0C
    pq.delete();
    wait_ready("b2b");
    iValid = 1'b1; iData = 8'h28; iRS = 1'b0;
    step();
    iData = 8'h0C;
    for (int i = 0; i < 200 && !oReady; i++) step();
    step();
    iValid = 1'b0;
    wait_pulses(4, "b2b");
    chk("b2b n0", int'(pget(0).data), 4'h2);
    chk("b2b n1", int'(pget(1).data), 4'h8);
    chk("b2b n2", int'(pget(2).data), 4'h0);
    chk("b2b n3", int'(pget(3).data), 4'hC);
    chk("b2b hi rise spacing", pget(2).rise - pget(0).rise, 20);

    // Reset during LO_EN: E drops immediately, then init restarts
    pq.delete();
    wait_ready("rst");
    iValid = 1'b1; iData = 8'h41; iRS = 1'b1;
    step();
    iValid = 1'b0;
    wait_pulses(1, "rst hi");
    for (int i = 0; i < 50 && !oLCD_E; i++) step();
    chk("rst in lo pulse", int'(oLCD_E), 1);
    Reset = 1'b1;
    #1;
    chk("rst E immediate", int'(oLCD_E), 0);
    chk("rst RS immediate", int'(oLCD_RS), 0);
    chk("rst data immediate", int'(oLCD_Data), 0);
    chk("rst ready immediate", int'(oReady), 0);
    chk("rst done immediate", int'(oInitDone), 0);
    repeat (2) step();
    pq.delete();
    Reset = 1'b0;
    rel = cyc;
    check_init(rel);
    chk("post-rst extra pulses", pq.size(), 4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
